id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode and execute in the segmented RV32I core. It captures the decoded instruction bundle and the register file read operands at each rising edge. It detects load-use hazards against the instruction in execute and inserts bubbles for them. It also bypasses the register file on same-cycle writeback, because the register file returns zero on both read ports whenever a write is in progress.

## Interface
Parameters:
- XLEN, 32, datapath width
- RADDR_W, 5, register index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of the decode instruction
- id_rs1, id_rs2, id_rd  in  RADDR_W  register indices
- id_uses_rs1, id_uses_rs2  in  1  the instruction actually reads rs1 / rs2
- id_ruRs1, id_ruRs2  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_ruWr, id_memRd, id_memWr  in  1  control bits
- id_aluOp  in  4  ALU operation
- id_aluASrc, id_aluBSrc  in  1  ALU operand selects
- id_brOp  in  5  branch operation
- id_dataWrSrc  in  2  writeback source select
- wb_ruWr  in  1  writeback write enable, same net as register file ruWr
- wb_rd  in  RADDR_W  writeback destination
- wb_dataWr  in  XLEN  writeback data
- stall  in  1  hold the stage (downstream memory busy)
- flush  in  1  kill the stage contents (taken branch or jump)
- ex_* outputs  out  same widths as the id_* bundle, plus ex_valid (1) and ex_rs1Data / ex_rs2Data (XLEN)
- load_use_hazard  out  1  combinational; upstream must hold PC and IF/ID
- bubble_cnt  out  CNT_W  saturating count of hazard bubbles inserted

## Operation
- Hazard, combinational:
  - load_use_hazard = ex_valid & ex_memRd & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Operand select for rs1, and identically for rs2:
  - If id_rs1 == 0: 0.
  - Else if wb_ruWr & wb_rd == id_rs1: wb_dataWr.
  - Else: id_ruRs1.
- Update priority at each rising edge, highest first:
  1. flush: load a bubble.
  2. stall: hold every register, including bubble_cnt.
  3. load_use_hazard: load a bubble and increment bubble_cnt.
  4. Otherwise: capture the id bundle and the selected operands.
- Bubble definition:
  - ex_valid, ex_ruWr, ex_memRd, ex_memWr, ex_brOp and ex_dataWrSrc all 0.
  - All other fields zeroed.
- Captured control bits are gated by id_valid: an invalid decode slot captures as a bubble but does not count.
- bubble_cnt saturates at all-ones. It counts only hazard bubbles, never flush bubbles.

## Timing
- Reset, asynchronous assert: every ex_* output is 0, ex_valid is 0 and bubble_cnt is 0. Release is synchronous to clk.
- Latency: 1 cycle from decode to the ex_* outputs.
- load_use_hazard is valid in the same cycle as its inputs. It has no registered delay.
- A load followed immediately by a dependent instruction costs exactly one bubble. In the cycle after the bubble, ex_memRd is 0, the hazard deasserts and the held instruction captures.
- Flush and hazard in the same cycle: flush wins and bubble_cnt is unchanged.
- Stall and hazard in the same cycle: hold wins, load_use_hazard stays asserted and bubble_cnt is unchanged.
- Writeback to rd = 0 never bypasses.
- Simultaneous wb match on rs1 and rs2: both operands take wb_dataWr.
- Reset asserted mid-stall or mid-hazard: the stage clears immediately and load_use_hazard drops to 0, because ex_valid goes to 0.

## Test plan
- Reset and first capture:
  - Assert rst_n=0 with non-zero inputs -> all outputs are 0.
  - Release and present id_pc=0x40, id_valid=1 -> after one edge, ex_pc=0x40 and ex_valid=1.
- Load-use:
  - ex holds lw x5, decode holds add x6,x5,x1 -> load_use_hazard=1.
  - Next edge -> ex_valid=0 and bubble_cnt=1.
  - Following edge -> the add captures and load_use_hazard=0.
- Writeback bypass:
  - id_rs1=7, id_ruRs1=0 (register file write in progress), wb_ruWr=1, wb_rd=7, wb_dataWr=0xDEADBEEF -> ex_rs1Data=0xDEADBEEF.
  - Same stimulus with wb_rd=0 -> ex_rs1Data=0.
- Priority:
  - flush=1 together with a hazard -> bubble loaded, bubble_cnt unchanged.
  - stall=1 -> every ex_* output holds for 3 cycles.
- Saturation:
  - Preload bubble_cnt to 0xFFFE and drive 3 hazards -> bubble_cnt=0xFFFF.
- Mid-operation reset:
  - Assert rst_n=0 asynchronously, between edges, while stall=1 -> outputs clear before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the segmented RV32I core: captures the decoded bundle,
// resolves same-cycle writeback bypass, and inserts bubbles on load-use hazards.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [XLEN-1:0]    id_ruRs1,
  input  logic [XLEN-1:0]    id_ruRs2,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_ruWr,
  input  logic               id_memRd,
  input  logic               id_memWr,
  input  logic [3:0]         id_aluOp,
  input  logic               id_aluASrc,
  input  logic               id_aluBSrc,
  input  logic [4:0]         id_brOp,
  input  logic [1:0]         id_dataWrSrc,
  input  logic               wb_ruWr,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_dataWr,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_uses_rs1,
  output logic               ex_uses_rs2,
  output logic [XLEN-1:0]    ex_imm,
  output logic               ex_ruWr,
  output logic               ex_memRd,
  output logic               ex_memWr,
  output logic [3:0]         ex_aluOp,
  output logic               ex_aluASrc,
  output logic               ex_aluBSrc,
  output logic [4:0]         ex_brOp,
  output logic [1:0]         ex_dataWrSrc,
  output logic [XLEN-1:0]    ex_rs1Data,
  output logic [XLEN-1:0]    ex_rs2Data,
  output logic               load_use_hazard,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Stage control is level-sensitive and sampled at each rising edge:
  // flush (load bubble) > stall (hold all) > hazard (load bubble, count) > capture.
  // load_use_hazard tells upstream to hold PC and IF/ID in the same cycle.

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [RADDR_W-1:0] r_rs1;
  logic [RADDR_W-1:0] r_rs2;
  logic [RADDR_W-1:0] r_rd;
  logic               r_uses_rs1;
  logic               r_uses_rs2;
  logic [XLEN-1:0]    r_imm;
  logic               r_ruWr;
  logic               r_memRd;
  logic               r_memWr;
  logic [3:0]         r_aluOp;
  logic               r_aluASrc;
  logic               r_aluBSrc;
  logic [4:0]         r_brOp;
  logic [1:0]         r_dataWrSrc;
  logic [XLEN-1:0]    r_rs1Data;
  logic [XLEN-1:0]    r_rs2Data;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic               w_hazard;
  logic               w_load_en;
  logic               w_capture;
  logic               w_cnt_inc;
  logic [XLEN-1:0]    w_rs1_data;
  logic [XLEN-1:0]    w_rs2_data;

  // The register file reads zero on both ports during a write, so a matching
  // writeback must be forwarded here; x0 always reads as zero.
  always_comb begin
    w_rs1_data = id_ruRs1;
    if (id_rs1 == '0) begin
      w_rs1_data = '0;
    end else if (wb_ruWr && (wb_rd == id_rs1)) begin
      w_rs1_data = wb_dataWr;
    end
  end

  always_comb begin
    w_rs2_data = id_ruRs2;
    if (id_rs2 == '0) begin
      w_rs2_data = '0;
    end else if (wb_ruWr && (wb_rd == id_rs2)) begin
      w_rs2_data = wb_dataWr;
    end
  end

  assign w_hazard = r_valid & r_memRd & (r_rd != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == r_rd)) |
                     (id_uses_rs2 & (id_rs2 == r_rd)));

  assign w_load_en = flush | ~stall;
  assign w_capture = ~flush & ~w_hazard & id_valid;
  assign w_cnt_inc = ~flush & ~stall & w_hazard & ~(&r_bubble_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_uses_rs1  <= 1'b0;
      r_uses_rs2  <= 1'b0;
      r_imm       <= '0;
      r_ruWr      <= 1'b0;
      r_memRd     <= 1'b0;
      r_memWr     <= 1'b0;
      r_aluOp     <= '0;
      r_aluASrc   <= 1'b0;
      r_aluBSrc   <= 1'b0;
      r_brOp      <= '0;
      r_dataWrSrc <= '0;
      r_rs1Data   <= '0;
      r_rs2Data   <= '0;
    end else if (w_load_en) begin
      if (w_capture) begin
        r_valid     <= 1'b1;
        r_pc        <= id_pc;
        r_rs1       <= id_rs1;
        r_rs2       <= id_rs2;
        r_rd        <= id_rd;
        r_uses_rs1  <= id_uses_rs1;
        r_uses_rs2  <= id_uses_rs2;
        r_imm       <= id_imm;
        r_ruWr      <= id_ruWr;
        r_memRd     <= id_memRd;
        r_memWr     <= id_memWr;
        r_aluOp     <= id_aluOp;
        r_aluASrc   <= id_aluASrc;
        r_aluBSrc   <= id_aluBSrc;
        r_brOp      <= id_brOp;
        r_dataWrSrc <= id_dataWrSrc;
        r_rs1Data   <= w_rs1_data;
        r_rs2Data   <= w_rs2_data;
      end else begin
        // Bubble: every field zero, so nothing downstream can act on it.
        r_valid     <= 1'b0;
        r_pc        <= '0;
        r_rs1       <= '0;
        r_rs2       <= '0;
        r_rd        <= '0;
        r_uses_rs1  <= 1'b0;
        r_uses_rs2  <= 1'b0;
        r_imm       <= '0;
        r_ruWr      <= 1'b0;
        r_memRd     <= 1'b0;
        r_memWr     <= 1'b0;
        r_aluOp     <= '0;
        r_aluASrc   <= 1'b0;
        r_aluBSrc   <= 1'b0;
        r_brOp      <= '0;
        r_dataWrSrc <= '0;
        r_rs1Data   <= '0;
        r_rs2Data   <= '0;
      end
    end
  end

  // Counts hazard bubbles only; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid        = r_valid;
  assign ex_pc           = r_pc;
  assign ex_rs1          = r_rs1;
  assign ex_rs2          = r_rs2;
  assign ex_rd           = r_rd;
  assign ex_uses_rs1     = r_uses_rs1;
  assign ex_uses_rs2     = r_uses_rs2;
  assign ex_imm          = r_imm;
  assign ex_ruWr         = r_ruWr;
  assign ex_memRd        = r_memRd;
  assign ex_memWr        = r_memWr;
  assign ex_aluOp        = r_aluOp;
  assign ex_aluASrc      = r_aluASrc;
  assign ex_aluBSrc      = r_aluBSrc;
  assign ex_brOp         = r_brOp;
  assign ex_dataWrSrc    = r_dataWrSrc;
  assign ex_rs1Data      = r_rs1Data;
  assign ex_rs2Data      = r_rs2Data;
  assign load_use_hazard = w_hazard;
  assign bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed hazard/priority/reset sequences and a
// short random run, all checked through an expected-value queue.
module tb_id_ex_stage;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] r1, r2, imm;
    logic        ruWr, memRd, memWr;
    logic [3:0]  aluOp;
    logic        aSrc, bSrc;
    logic [4:0]  brOp;
    logic [1:0]  dws;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] imm;
    logic        ruWr, memRd, memWr;
    logic [3:0]  aluOp;
    logic        aSrc, bSrc;
    logic [4:0]  brOp;
    logic [1:0]  dws;
    logic [31:0] rs1d, rs2d;
  } ex_t;

  localparam int EXW = $bits(ex_t);

  typedef struct {
    id_t         d;
    logic        wr;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] e1, e2;
  } vec_t;

  logic          clk, rst_n;
  id_t           cur_id;
  logic          wb_ruWr;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_dataWr;
  logic          stall, flush;

  logic          ex_valid, ex_uses_rs1, ex_uses_rs2, ex_ruWr, ex_memRd, ex_memWr;
  logic          ex_aluASrc, ex_aluBSrc, load_use_hazard;
  logic [31:0]   ex_pc, ex_imm, ex_rs1Data, ex_rs2Data;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd, ex_brOp;
  logic [3:0]    ex_aluOp;
  logic [1:0]    ex_dataWrSrc;
  logic [CW-1:0] bubble_cnt;

  logic [EXW-1:0] exp_q[$];
  ex_t            cur_ex;
  logic [CW-1:0]  exp_cnt;
  int             n_cmp, n_err;

  id_ex_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur_id.valid), .id_pc(cur_id.pc),
    .id_rs1(cur_id.rs1), .id_rs2(cur_id.rs2), .id_rd(cur_id.rd),
    .id_uses_rs1(cur_id.u1), .id_uses_rs2(cur_id.u2),
    .id_ruRs1(cur_id.r1), .id_ruRs2(cur_id.r2), .id_imm(cur_id.imm),
    .id_ruWr(cur_id.ruWr), .id_memRd(cur_id.memRd), .id_memWr(cur_id.memWr),
    .id_aluOp(cur_id.aluOp), .id_aluASrc(cur_id.aSrc), .id_aluBSrc(cur_id.bSrc),
    .id_brOp(cur_id.brOp), .id_dataWrSrc(cur_id.dws),
    .wb_ruWr(wb_ruWr), .wb_rd(wb_rd), .wb_dataWr(wb_dataWr),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2), .ex_imm(ex_imm),
    .ex_ruWr(ex_ruWr), .ex_memRd(ex_memRd), .ex_memWr(ex_memWr),
    .ex_aluOp(ex_aluOp), .ex_aluASrc(ex_aluASrc), .ex_aluBSrc(ex_aluBSrc),
    .ex_brOp(ex_brOp), .ex_dataWrSrc(ex_dataWrSrc),
    .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data),
    .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / model ----------------
  function automatic id_t instr(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic u1, logic u2, logic ld);
    id_t d;
    d       = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.rs1   = rs1;
    d.rs2   = rs2;
    d.rd    = rd;
    d.u1    = u1;
    d.u2    = u2;
    d.r1    = 32'h1000_0000 | {27'd0, rs1};
    d.r2    = 32'h2000_0000 | {27'd0, rs2};
    d.imm   = pc ^ 32'h5a5a_0000;
    d.ruWr  = 1'b1;
    d.memRd = ld;
    d.aluOp = pc[5:2];
    d.aSrc  = pc[2];
    d.bSrc  = ld;
    d.brOp  = ld ? 5'd0 : {1'b0, pc[5:2]};
    d.dws   = ld ? 2'd1 : 2'd0;
    return d;
  endfunction

  function automatic logic hz_model(ex_t e, id_t d);
    return e.valid && e.memRd && (e.rd != 5'd0) && d.valid &&
           ((d.u1 && (d.rs1 == e.rd)) || (d.u2 && (d.rs2 == e.rd)));
  endfunction

  function automatic logic [31:0] opnd(logic [4:0] rs, logic [31:0] rf,
                                       logic wr, logic [4:0] wrd, logic [31:0] wd);
    if (rs == 5'd0) return 32'd0;
    if (wr && (wrd == rs)) return wd;
    return rf;
  endfunction

  function automatic ex_t cap_model(id_t d, logic wr, logic [4:0] wrd, logic [31:0] wd);
    ex_t e;
    e = '0;
    if (!d.valid) return e;
    e.valid = 1'b1;  e.pc = d.pc;  e.rs1 = d.rs1;  e.rs2 = d.rs2;  e.rd = d.rd;
    e.u1 = d.u1;  e.u2 = d.u2;  e.imm = d.imm;
    e.ruWr = d.ruWr;  e.memRd = d.memRd;  e.memWr = d.memWr;
    e.aluOp = d.aluOp;  e.aSrc = d.aSrc;  e.bSrc = d.bSrc;
    e.brOp = d.brOp;  e.dws = d.dws;
    e.rs1d = opnd(d.rs1, d.r1, wr, wrd, wd);
    e.rs2d = opnd(d.rs2, d.r2, wr, wrd, wd);
    return e;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid = ex_valid;  e.pc = ex_pc;  e.rs1 = ex_rs1;  e.rs2 = ex_rs2;  e.rd = ex_rd;
    e.u1 = ex_uses_rs1;  e.u2 = ex_uses_rs2;  e.imm = ex_imm;
    e.ruWr = ex_ruWr;  e.memRd = ex_memRd;  e.memWr = ex_memWr;
    e.aluOp = ex_aluOp;  e.aSrc = ex_aluASrc;  e.bSrc = ex_aluBSrc;
    e.brOp = ex_brOp;  e.dws = ex_dataWrSrc;
    e.rs1d = ex_rs1Data;  e.rs2d = ex_rs2Data;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ex(string name, ex_t exp);
    ex_t act;
    act = dut_ex();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: ex bundle got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sb(string name);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty got output expected queued entry", name);
    end else begin
      chk_ex(name, ex_t'(exp_q.pop_front()));
    end
  endtask

  // One clock: check the combinational hazard, predict the next ex state, clock, compare.
  task automatic cycle(string name);
    ex_t  e;
    logic hz;
    #1;
    hz = hz_model(cur_ex, cur_id);
    chk({name, "/hazard"}, {31'd0, load_use_hazard}, {31'd0, hz});
    if (flush) e = '0;
    else if (stall) e = cur_ex;
    else if (hz) begin
      e = '0;
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end else e = cap_model(cur_id, wb_ruWr, wb_rd, wb_dataWr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk_sb(name);
    chk({name, "/cnt"}, {28'd0, bubble_cnt}, {28'd0, exp_cnt});
    cur_ex = e;
  endtask

  function automatic vec_t mkv(id_t d, logic [31:0] r1, logic [31:0] r2, logic v,
                               logic wr, logic [4:0] wrd, logic [31:0] wd,
                               logic [31:0] e1, logic [31:0] e2);
    vec_t t;
    t.d = d;  t.d.r1 = r1;  t.d.r2 = r2;  t.d.valid = v;
    t.wr = wr;  t.wrd = wrd;  t.wd = wd;  t.e1 = e1;  t.e2 = e2;
    return t;
  endfunction

  // ---------------- test ----------------
  vec_t tbl[9];
  id_t  lw, add;
  int   k;

  initial begin
    tbl[0] = mkv(instr(32'h100, 5'd1,  5'd2,  5'd3, 1, 1, 0), 32'h11, 32'h22, 1,
                 0, 5'd0,  32'h0,        32'h11,       32'h22);
    tbl[1] = mkv(instr(32'h104, 5'd7,  5'd3,  5'd4, 1, 1, 0), 32'h0, 32'h0, 1,
                 1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    tbl[2] = mkv(instr(32'h108, 5'd7,  5'd3,  5'd4, 1, 1, 0), 32'h0, 32'h0, 1,
                 1, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0);
    tbl[3] = mkv(instr(32'h10c, 5'd0,  5'd4,  5'd8, 1, 1, 0), 32'h55, 32'h44, 1,
                 1, 5'd0,  32'hCAFEF00D, 32'h0,        32'h44);
    tbl[4] = mkv(instr(32'h110, 5'd9,  5'd9,  5'd1, 1, 1, 0), 32'h0, 32'h0, 1,
                 1, 5'd9,  32'h12345678, 32'h12345678, 32'h12345678);
    tbl[5] = mkv(instr(32'h114, 5'd10, 5'd11, 5'd2, 1, 1, 0), 32'hAAAA, 32'hBBBB, 1,
                 0, 5'd10, 32'h9999,     32'hAAAA,     32'hBBBB);
    tbl[6] = mkv(instr(32'h118, 5'd12, 5'd13, 5'd3, 0, 1, 0), 32'h0, 32'h0, 1,
                 1, 5'd13, 32'h0BADCAFE, 32'h0,        32'h0BADCAFE);
    tbl[7] = mkv(instr(32'h11c, 5'd14, 5'd15, 5'd4, 1, 1, 0), 32'h77, 32'h88, 0,
                 0, 5'd0,  32'h0,        32'h0,        32'h0);
    tbl[8] = mkv(instr(32'h120, 5'd31, 5'd30, 5'd5, 1, 1, 0), 32'hFFFFFFFF, 32'h80000000, 1,
                 1, 5'd31, 32'h1,        32'h1,        32'h80000000);

    n_cmp = 0;  n_err = 0;  exp_cnt = '0;  cur_ex = '0;

    // Reset with busy, non-zero inputs.
    rst_n = 1'b0;  stall = 1'b0;  flush = 1'b0;
    cur_id = instr(32'h1234, 5'd5, 5'd6, 5'd7, 1, 1, 1);
    wb_ruWr = 1'b1;  wb_rd = 5'd5;  wb_dataWr = 32'h5555_AAAA;
    #3;
    chk_ex("reset_async", '0);
    chk("reset_cnt", {28'd0, bubble_cnt}, 32'd0);
    chk("reset_hazard", {31'd0, load_use_hazard}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset_held", '0);

    @(negedge clk);
    rst_n = 1'b1;
    cur_id = instr(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 0);
    wb_ruWr = 1'b0;
    cycle("first");
    chk("first_pc", ex_pc, 32'h40);
    chk("first_valid", {31'd0, ex_valid}, 32'd1);

    // Vector table: operand select and bypass.
    for (int i = 0; i < 9; i++) begin
      cur_id = tbl[i].d;  wb_ruWr = tbl[i].wr;  wb_rd = tbl[i].wrd;  wb_dataWr = tbl[i].wd;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rs1d", i), ex_rs1Data, tbl[i].e1);
      chk($sformatf("vec%0d_rs2d", i), ex_rs2Data, tbl[i].e2);
    end
    wb_ruWr = 1'b0;

    // Load-use: lw x5 then add x6,x5,x1.
    lw  = instr(32'h200, 5'd2, 5'd0, 5'd5, 1, 0, 1);
    add = instr(32'h204, 5'd5, 5'd1, 5'd6, 1, 1, 0);
    cur_id = lw;   cycle("lu_lw");
    cur_id = add;  #1;
    chk("lu_hz_on", {31'd0, load_use_hazard}, 32'd1);
    cycle("lu_bubble");
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_cnt", {28'd0, bubble_cnt}, 32'd1);
    #1;
    chk("lu_hz_off", {31'd0, load_use_hazard}, 32'd0);
    cycle("lu_capture");
    chk("lu_capture_pc", ex_pc, 32'h204);

    // Flush beats hazard.
    cur_id = lw;   cycle("fl_lw");
    cur_id = add;  flush = 1'b1;
    cycle("fl_bubble");
    chk("fl_cnt", {28'd0, bubble_cnt}, 32'd1);
    flush = 1'b0;
    cycle("fl_after");

    // Stall beats hazard; everything holds for 3 cycles.
    cur_id = lw;   cycle("st_lw");
    cur_id = add;  stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur_id.pc = cur_id.pc + 32'd4;
      wb_ruWr = 1'b1;  wb_rd = 5'd5;  wb_dataWr = 32'hF00D_0000 + i;
      cycle("st_hold");
      chk("st_hold_pc", ex_pc, 32'h200);
      chk("st_hold_hz", {31'd0, load_use_hazard}, 32'd1);
    end
    stall = 1'b0;  wb_ruWr = 1'b0;
    cycle("st_release");
    cycle("st_capture");

    // Non-hazards: unused source, load to x0.
    cur_id = lw;  cycle("nh_lw");
    cur_id = instr(32'h240, 5'd5, 5'd5, 5'd6, 0, 0, 0);  cycle("nh_unused");
    cur_id = instr(32'h244, 5'd1, 5'd0, 5'd0, 1, 0, 1);  cycle("nh_lw_x0");
    cur_id = instr(32'h248, 5'd0, 5'd0, 5'd7, 1, 1, 0);  cycle("nh_dep_x0");

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      cur_id = instr($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cur_id.valid = ($urandom_range(0, 3) != 0);
      cur_id.memWr = 1'($urandom_range(0, 1));
      wb_ruWr   = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 7));
      wb_dataWr = $urandom;
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    stall = 1'b0;  flush = 1'b0;  wb_ruWr = 1'b0;

    // Saturation: preload to max-1, then three more hazards.
    cur_id = instr(32'h500, 5'd5, 5'd0, 5'd5, 1, 0, 1);
    for (int i = 0; i < 100 && exp_cnt < CW'(14); i++) cycle("sat_pre");
    chk("sat_preload", {28'd0, bubble_cnt}, 32'd14);
    k = 0;
    for (int i = 0; i < 12 && k < 3; i++) begin
      #1;
      if (hz_model(cur_ex, cur_id)) k++;
      cycle("sat_run");
    end
    chk("sat_hazards", k, 32'd3);
    chk("sat_cnt", {28'd0, bubble_cnt}, 32'hF);

    // Reset between edges while stalled on a hazard.
    cur_id = instr(32'h600, 5'd2, 5'd0, 5'd5, 1, 0, 1);  cycle("mr_lw");
    cur_id = instr(32'h604, 5'd5, 5'd1, 5'd6, 1, 1, 0);  stall = 1'b1;
    cycle("mr_stall");
    #3;
    rst_n = 1'b0;
    #1;
    chk_ex("mr_clear", '0);
    chk("mr_cnt", {28'd0, bubble_cnt}, 32'd0);
    chk("mr_hz", {31'd0, load_use_hazard}, 32'd0);
    @(posedge clk);
    #1;
    chk_ex("mr_held", '0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
